snowv_lfsr_ctrl: RTL and testbench

Dual 256-bit LFSR (LFSR-A, LFSR-B) of the SNOW-V cipher plus its key/IV load and initialisation controller. It sits directly upstream of the SNOW-V FSM stage. It supplies the FSM's 128-bit taps T1/T2 every clock, feeds the FSM keystream back into LFSR-A during the 16 initialisation rounds, and flags when the FSM output is valid keystream. It advances exactly once per clock while running, staying in lock-step with the FSM registers.

---
 rtl/snowv_lfsr_ctrl_if.sv | 41 ++++
 rtl/snowv_lfsr_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_snowv_lfsr_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snowv_lfsr_ctrl_if.sv
// ---------------------------------------------------------------------------
// snowv_lfsr_ctrl_if
//
// Bundle between the SNOW-V LFSR/controller block and its surroundings (the
// key/IV source upstream and the SNOW-V FSM stage downstream).
//
//   start      load key/IV and begin initialisation
//   key[255:0] k15..k0, 16-bit cells, k_i = key[16i+15:16i]
//   iv[127:0]  iv7..iv0, same packing
//   z_in       FSM keystream output, combinational in the current cycle
//   t1         b15..b8 tap towards the FSM (b8 in [15:0])
//   t2         a7..a0 tap towards the FSM (a0 in [15:0])
//   r1_xor     value the FSM XORs into its next R1
//   fsm_clear  FSM registers load zero on this edge
//   ks_valid   z_in is valid keystream this cycle
//   busy       initialisation in progress
//
// The slave modport is the LFSR block itself; master is whoever drives it.
// ---------------------------------------------------------------------------
interface snowv_lfsr_ctrl_if;
    logic         start;
    logic [255:0] key;
    logic [127:0] iv;
    logic [127:0] z_in;
    logic [127:0] t1;
    logic [127:0] t2;
    logic [127:0] r1_xor;
    logic         fsm_clear;
    logic         ks_valid;
    logic         busy;

    modport master (
        output start, key, iv, z_in,
        input  t1, t2, r1_xor, fsm_clear, ks_valid, busy
    );

    modport slave (
        input  start, key, iv, z_in,
        output t1, t2, r1_xor, fsm_clear, ks_valid, busy
    );
endinterface

// File: rtl/snowv_lfsr_ctrl.sv
// ---------------------------------------------------------------------------
// snowv_lfsr_ctrl
//
// The two 256-bit LFSRs (A and B) of SNOW-V together with the key/IV load
// and initialisation controller. Each register holds sixteen 16-bit cells,
// cell i at [16i+15:16i]. While running, both registers advance by eight
// cells per clock, in lock-step with the downstream FSM registers.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (priority over start)
//   bus   snowv_lfsr_ctrl_if.slave: start/key/iv/z_in in,
//         t1/t2/r1_xor/fsm_clear/ks_valid/busy out
//
// Sequencing: a start seen in IDLE or RUN loads key/IV on that edge and
// enters INIT with cnt = 0. INIT lasts INIT_ROUNDS clocks, during which the
// FSM keystream is folded back into the upper half of A. The edge that
// sees cnt == INIT_ROUNDS-1 moves to RUN, where z_in is valid keystream.
// A start while in INIT is ignored so the schedule cannot be disturbed.
// ---------------------------------------------------------------------------
module snowv_lfsr_ctrl #(
    parameter int INIT_ROUNDS = 16
) (
    input  logic               clk,
    input  logic               rst,
    snowv_lfsr_ctrl_if.slave   bus
);

    localparam int CNT_W = (INIT_ROUNDS > 2) ? $clog2(INIT_ROUNDS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_ROUNDS - 1);
    localparam logic [CNT_W-1:0] CNT_PENU = CNT_W'(INIT_ROUNDS - 2);

    // Field polynomials: multiplication by alpha / division by alpha for A,
    // and the corresponding beta constants for B.
    localparam logic [15:0] MUL_A = 16'h990F;
    localparam logic [15:0] INV_A = 16'hCC87;
    localparam logic [15:0] MUL_B = 16'hC963;
    localparam logic [15:0] INV_B = 16'hE4B1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // GF(2^16) helpers
    // -----------------------------------------------------------------------
    function automatic logic [15:0] gf_mul(input logic [15:0] v, input logic [15:0] c);
        gf_mul = v[15] ? ({v[14:0], 1'b0} ^ c) : {v[14:0], 1'b0};
    endfunction

    function automatic logic [15:0] gf_inv(input logic [15:0] v, input logic [15:0] d);
        gf_inv = v[0] ? ({1'b0, v[15:1]} ^ d) : {1'b0, v[15:1]};
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [255:0]     a_reg;
    logic [255:0]     a_next;
    logic [255:0]     b_reg;
    logic [255:0]     b_next;
    logic [255:0]     key_reg;
    logic [255:0]     key_next;

    logic             load;
    logic             step;
    logic             in_init;

    logic [127:0]     na_cells;
    logic [127:0]     nb_cells;

    logic [127:0]     r1_xor_comb;
    logic             fsm_clear_comb;
    logic             ks_valid_comb;
    logic             busy_comb;

    assign in_init = (state_reg == ST_INIT);
    assign load    = bus.start && !in_init;
    assign step    = (state_reg != ST_IDLE);

    // -----------------------------------------------------------------------
    // Feedback cells. All eight new cells of each register are computed from
    // the pre-edge contents only, so there is no chain between cells within
    // one clock.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cell
            assign na_cells[16*gi +: 16] = b_reg[16*gi +: 16]
                                         ^ gf_mul(a_reg[16*gi +: 16], MUL_A)
                                         ^ a_reg[16*(gi+1) +: 16]
                                         ^ gf_inv(a_reg[16*(gi+8) +: 16], INV_A);

            assign nb_cells[16*gi +: 16] = a_reg[16*gi +: 16]
                                         ^ gf_mul(b_reg[16*gi +: 16], MUL_B)
                                         ^ b_reg[16*(gi+3) +: 16]
                                         ^ gf_inv(b_reg[16*(gi+8) +: 16], INV_B);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_INIT;
                end
            end
            ST_INIT: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Restart: reload and re-initialise from scratch.
                if (bus.start) begin
                    state_next = ST_INIT;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output decode
    // -----------------------------------------------------------------------
    always_comb begin
        fsm_clear_comb = 1'b0;
        ks_valid_comb  = 1'b0;
        busy_comb      = 1'b0;
        r1_xor_comb    = '0;
        case (state_reg)
            ST_IDLE: begin
                fsm_clear_comb = 1'b1;
            end
            ST_INIT: begin
                busy_comb = 1'b1;
                // The key is mixed into R1 during the final two init rounds.
                if (cnt_reg == CNT_PENU) begin
                    r1_xor_comb = key_reg[127:0];
                end else if (cnt_reg == CNT_LAST) begin
                    r1_xor_comb = key_reg[255:128];
                end
            end
            ST_RUN: begin
                ks_valid_comb = 1'b1;
            end
            default: begin
                fsm_clear_comb = 1'b1;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        a_next   = a_reg;
        b_next   = b_reg;
        key_next = key_reg;
        cnt_next = cnt_reg;
        if (load) begin
            a_next   = {bus.key[127:0], bus.iv};
            b_next   = {bus.key[255:128], 128'd0};
            key_next = bus.key;
            cnt_next = '0;
        end else if (step) begin
            a_next = {na_cells, a_reg[255:128]};
            b_next = {nb_cells, b_reg[255:128]};
            if (in_init) begin
                // Keystream feedback: one XOR level behind the new A cells.
                a_next[255:128] = na_cells ^ bus.z_in;
                cnt_next        = cnt_reg + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            key_reg <= '0;
            cnt_reg <= '0;
        end else begin
            a_reg   <= a_next;
            b_reg   <= b_next;
            key_reg <= key_next;
            cnt_reg <= cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. The taps come straight from register bits.
    // -----------------------------------------------------------------------
    assign bus.t1        = b_reg[255:128];
    assign bus.t2        = a_reg[127:0];
    assign bus.r1_xor    = r1_xor_comb;
    assign bus.fsm_clear = fsm_clear_comb;
    assign bus.ks_valid  = ks_valid_comb;
    assign bus.busy      = busy_comb;

endmodule

// File: tb/tb_snowv_lfsr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snowv_lfsr_ctrl
//
// Bench for snowv_lfsr_ctrl. A cell-array reference model is advanced on
// every driven cycle and its predicted outputs are queued; each scenario
// task pops the prediction after the clock edge and compares it with the
// DUT outputs, alongside hand-derived constants for the known cases.
// ---------------------------------------------------------------------------
module tb_snowv_lfsr_ctrl;

    localparam int ROUNDS = 16;

    typedef struct packed {
        logic [127:0] t1;
        logic [127:0] t2;
        logic [127:0] r1;
        logic         fc;
        logic         kv;
        logic         bz;
    } obs_t;

    logic clk;
    logic rst;

    snowv_lfsr_ctrl_if bus ();

    snowv_lfsr_ctrl #(.INIT_ROUNDS(ROUNDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run    = 0;
    int tests_failed = 0;

    obs_t sb_q[$];
    obs_t ref_traj [1:24];
    logic [127:0] z_seq [1:24];
    logic [255:0] ref_key;
    logic [127:0] ref_iv;

    // ---------------- reference model ----------------
    logic [15:0]  ma [16];
    logic [15:0]  mb [16];
    logic [255:0] mkey;
    int           mstate;   // 0 idle, 1 init, 2 run
    int           mcnt;

    function automatic logic [15:0] mul16(input logic [15:0] v, input logic [15:0] c);
        logic [15:0] r;
        r = v << 1;
        if (v[15]) r = r ^ c;
        return r;
    endfunction

    function automatic logic [15:0] inv16(input logic [15:0] v, input logic [15:0] d);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ d;
        return r;
    endfunction

    task automatic model_edge(input logic r, input logic s, input logic [255:0] k,
                              input logic [127:0] v, input logic [127:0] z);
        logic [15:0] na [8];
        logic [15:0] nb [8];
        if (r) begin
            for (int i = 0; i < 16; i++) begin
                ma[i] = 16'h0;
                mb[i] = 16'h0;
            end
            mkey = '0; mstate = 0; mcnt = 0;
        end else if (s && mstate != 1) begin
            for (int i = 0; i < 8; i++) begin
                ma[i]     = v[16*i +: 16];
                ma[i + 8] = k[16*i +: 16];
                mb[i]     = 16'h0;
                mb[i + 8] = k[128 + 16*i +: 16];
            end
            mkey = k; mstate = 1; mcnt = 0;
        end else if (mstate != 0) begin
            for (int j = 0; j < 8; j++) begin
                na[j] = mb[j] ^ mul16(ma[j], 16'h990F) ^ ma[j+1] ^ inv16(ma[j+8], 16'hCC87);
                nb[j] = ma[j] ^ mul16(mb[j], 16'hC963) ^ mb[j+3] ^ inv16(mb[j+8], 16'hE4B1);
            end
            for (int j = 0; j < 8; j++) begin
                ma[j] = ma[j+8];
                mb[j] = mb[j+8];
                ma[j+8] = na[j];
                mb[j+8] = nb[j];
            end
            if (mstate == 1) begin
                for (int j = 0; j < 8; j++) ma[j+8] = ma[j+8] ^ z[16*j +: 16];
                if (mcnt == ROUNDS - 1) mstate = 2;
                mcnt++;
            end
        end
    endtask

    function automatic obs_t model_out();
        obs_t o;
        for (int j = 0; j < 8; j++) begin
            o.t1[16*j +: 16] = mb[j+8];
            o.t2[16*j +: 16] = ma[j];
        end
        o.r1 = '0;
        if (mstate == 1 && mcnt == ROUNDS - 2) o.r1 = mkey[127:0];
        else if (mstate == 1 && mcnt == ROUNDS - 1) o.r1 = mkey[255:128];
        o.fc = (mstate == 0);
        o.kv = (mstate == 2);
        o.bz = (mstate == 1);
        return o;
    endfunction

    function automatic obs_t dut_obs();
        return {bus.t1, bus.t2, bus.r1_xor, bus.fsm_clear, bus.ks_valid, bus.busy};
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one cycle of inputs, predict the post-edge outputs, clock.
    task automatic tick(input logic r, input logic s, input logic [255:0] k,
                        input logic [127:0] v, input logic [127:0] z);
        @(negedge clk);
        rst       = r;
        bus.start = s;
        bus.key   = k;
        bus.iv    = v;
        bus.z_in  = z;
        model_edge(r, s, k, v, z);
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        obs_t exp, got;
        tick(1'b1, 1'b0, '0, '0, '0);
        exp = sb_q.pop_front(); got = dut_obs();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL go_idle got=%h exp=%h", got, exp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        obs_t exp, got;
        obs_t idle_c;
        idle_c = '0; idle_c.fc = 1'b1;
        for (int c = 0; c < 3; c++) begin
            // two reset cycles with start also high, then one quiet cycle
            tick(c < 2, 1'b1 && (c < 2), rand256(), rand128(), rand128());
            exp = sb_q.pop_front(); got = dut_obs();
            tests_run++;
            if (got !== exp || got !== idle_c) begin
                tests_failed++;
                $display("FAIL reset c%0d got=%h exp=%h", c, got, idle_c);
            end
        end
    endtask

    task automatic test_load();
        obs_t exp, got;
        logic [255:0] k;
        k = '0; k[128] = 1'b1;
        tick(1'b0, 1'b1, k, 128'h5, '0);
        exp = sb_q.pop_front(); got = dut_obs();
        tests_run++;
        if (got !== exp || got.t1[15:0] !== 16'h0001 || got.t2[15:0] !== 16'h0005 || got.bz !== 1'b1) begin
            tests_failed++;
            $display("FAIL load got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_alpha_step();
        obs_t exp, got;
        go_idle();
        tick(1'b0, 1'b1, '0, 128'h1, '0);
        exp = sb_q.pop_front(); got = dut_obs();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL alpha_load got=%h exp=%h", got, exp);
        end
        tick(1'b0, 1'b0, '0, '0, '0);
        exp = sb_q.pop_front(); got = dut_obs();
        tests_run++;
        if (got !== exp || got.t1 !== 128'h1 || got.t2 !== 128'h0) begin
            tests_failed++;
            $display("FAIL alpha_step got t1=%h t2=%h exp t1=1 t2=0", got.t1, got.t2);
        end
        // a8 from the previous step is now a0
        tick(1'b0, 1'b0, '0, '0, '0);
        exp = sb_q.pop_front(); got = dut_obs();
        tests_run++;
        if (got !== exp || got.t2[15:0] !== 16'h0002) begin
            tests_failed++;
            $display("FAIL alpha_a8 got=%h exp=0002", got.t2[15:0]);
        end
    endtask

    task automatic test_alpha_inv_step();
        obs_t exp, got;
        go_idle();
        tick(1'b0, 1'b1, 256'h1, '0, '0);
        exp = sb_q.pop_front(); got = dut_obs();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL ainv_load got=%h exp=%h", got, exp);
        end
        tick(1'b0, 1'b0, '0, '0, '0);
        exp = sb_q.pop_front(); got = dut_obs();
        tests_run++;
        if (got !== exp || got.t2 !== 128'h1 || got.t1 !== 128'h0) begin
            tests_failed++;
            $display("FAIL ainv_step got t1=%h t2=%h exp t1=0 t2=1", got.t1, got.t2);
        end
        tick(1'b0, 1'b0, '0, '0, '0);
        exp = sb_q.pop_front(); got = dut_obs();
        tests_run++;
        if (got !== exp || got.t2[15:0] !== 16'hCC87) begin
            tests_failed++;
            $display("FAIL ainv_a8 got=%h exp=cc87", got.t2[15:0]);
        end
    endtask

    task automatic test_feedback();
        obs_t exp, got;
        logic [255:0] k;
        logic [127:0] v;
        logic [127:0] t2_zero;
        k = rand256(); v = rand128();
        t2_zero = '0;
        for (int run = 0; run < 2; run++) begin
            go_idle();
            tick(1'b0, 1'b1, k, v, '0);
            exp = sb_q.pop_front(); got = dut_obs();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL fb_load r%0d got=%h exp=%h", run, got, exp);
            end
            tick(1'b0, 1'b0, '0, '0, (run == 0) ? 128'h0 : {128{1'b1}});
            exp = sb_q.pop_front(); got = dut_obs();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL fb_step r%0d got=%h exp=%h", run, got, exp);
            end
            tick(1'b0, 1'b0, '0, '0, '0);
            exp = sb_q.pop_front(); got = dut_obs();
            if (run == 0) t2_zero = exp.t2;
            tests_run++;
            if (got !== exp || (run == 1 && got.t2 !== ~t2_zero)) begin
                tests_failed++;
                $display("FAIL fb_upper r%0d got=%h exp=%h", run, got.t2, (run == 1) ? ~t2_zero : exp.t2);
            end
        end
    endtask

    task automatic test_schedule();
        obs_t exp, got;
        logic [255:0] k;
        logic [127:0] r1_exp;
        k = rand256();
        go_idle();
        for (int c = 1; c <= 18; c++) begin
            tick(1'b0, c == 1, k, rand128(), rand128());
            exp = sb_q.pop_front(); got = dut_obs();
            r1_exp = (c == 15) ? k[127:0] : (c == 16) ? k[255:128] : 128'h0;
            tests_run++;
            if (got !== exp || got.r1 !== r1_exp || got.bz !== (c <= 16) || got.kv !== (c >= 17)) begin
                tests_failed++;
                $display("FAIL sched c%0d got r1=%h bz=%b kv=%b exp r1=%h bz=%b kv=%b",
                         c, got.r1, got.bz, got.kv, r1_exp, c <= 16, c >= 17);
            end
        end
    endtask

    task automatic test_init_start_ignored();
        obs_t exp, got;
        logic [255:0] k;
        k = rand256();
        go_idle();
        for (int c = 1; c <= 18; c++) begin
            tick(1'b0, (c == 1) || (c == 6) || (c == 10), (c == 1) ? k : rand256(), rand128(), rand128());
            exp = sb_q.pop_front(); got = dut_obs();
            tests_run++;
            if (got !== exp || got.bz !== (c <= 16) || got.kv !== (c >= 17)) begin
                tests_failed++;
                $display("FAIL init_start c%0d got=%h exp=%h", c, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t exp, got;
        go_idle();
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 1; c <= 20; c++) begin
                tick(1'b0, c == 1, ref_key, ref_iv, z_seq[c]);
                exp = sb_q.pop_front(); got = dut_obs();
                if (pass == 0) ref_traj[c] = exp;
                tests_run++;
                if (got !== exp || got !== ref_traj[c] ||
                    (pass == 1 && c == 1 && (got.kv !== 1'b0 || got.bz !== 1'b1))) begin
                    tests_failed++;
                    $display("FAIL restart p%0d c%0d got=%h exp=%h", pass, c, got, ref_traj[c]);
                end
            end
        end
    endtask

    task automatic test_rst_abort();
        obs_t exp, got;
        obs_t idle_c;
        idle_c = '0; idle_c.fc = 1'b1;
        go_idle();
        for (int c = 1; c <= 8; c++) begin
            tick(1'b0, c == 1, ref_key, ref_iv, z_seq[c]);
            exp = sb_q.pop_front(); got = dut_obs();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL abort_pre c%0d got=%h exp=%h", c, got, exp);
            end
        end
        // reset at cnt = 7 with start also high
        tick(1'b1, 1'b1, rand256(), rand128(), rand128());
        exp = sb_q.pop_front(); got = dut_obs();
        tests_run++;
        if (got !== exp || got !== idle_c) begin
            tests_failed++;
            $display("FAIL abort_rst got=%h exp=%h", got, idle_c);
        end
        for (int c = 1; c <= 20; c++) begin
            tick(1'b0, c == 1, ref_key, ref_iv, z_seq[c]);
            exp = sb_q.pop_front(); got = dut_obs();
            tests_run++;
            if (got !== exp || got !== ref_traj[c]) begin
                tests_failed++;
                $display("FAIL abort_rerun c%0d got=%h exp=%h", c, got, ref_traj[c]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.key   = '0;
        bus.iv    = '0;
        bus.z_in  = '0;
        ref_key   = rand256();
        ref_iv    = rand128();
        for (int i = 1; i <= 24; i++) begin
            z_seq[i]    = rand128();
            ref_traj[i] = '0;
        end

        test_reset();
        test_load();
        test_alpha_step();
        test_alpha_inv_step();
        test_feedback();
        test_schedule();
        test_init_start_ignored();
        test_back_to_back();
        test_rst_abort();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
